alu_arbiter: RTL
================

# alu_arbiter

Shares one `alu` instance between `NUM_REQ` requesters. Each requester has a valid/ready port carrying operands and opcode. A round-robin arbiter issues at most one operation per cycle and sequences the ALU's two-stage timing: operands are sampled one edge, the opcode the next. Results return tagged with the requester id through an internal credit-protected response FIFO with valid/ready backpressure.

## Interface
- `NUM_REQ`, default 4: number of requesters, range 2..8.
- `FIFO_DEPTH`, default 4: response FIFO entries, power of two, at least 4.
- `ID_W`, localparam $clog2(NUM_REQ): requester id width.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in [NUM_REQ]: request present, one bit per requester.
- `req_ready` out [NUM_REQ]: request accepted this cycle; at most one bit set.
- `req_a` in [NUM_REQ][32]: signed operand a, per requester.
- `req_b` in [NUM_REQ][32]: signed operand b, per requester.
- `req_op` in [NUM_REQ][3]: opcode (`alu_op_e`), per requester.
- `rsp_valid` out 1: FIFO head valid.
- `rsp_ready` in 1: consumer accepts the head.
- `rsp_id` out ID_W: requester that issued the head result.
- `rsp_r` out 32: signed result.
- `busy` out 1: high while any operation is in flight or the FIFO is non-empty.

## Operation
- Opcodes:
  - 000 ADD: a+b
  - 001 SUB: a−b
  - 010 NOT: ~a
  - 011 NAND: ~(a&b)
  - 100 NOR: ~(a|b)
  - 101 AND
  - 110 OR
  - 111 XOR
- Arithmetic is 32-bit two's complement and wraps; no overflow flag.
- Credit rule: `can_issue = s1_valid + s2_valid + fifo_count < FIFO_DEPTH`.
  - The count is conservative: a same-cycle pop is not counted.
  - The FIFO therefore never overflows; a push to a full FIFO is a design error and is asserted against.
- Arbitration: round-robin over `req_valid`, starting at `rr_ptr+1` and wrapping modulo NUM_REQ.
  - Grant i: `req_ready[i] = grant[i] & can_issue`. This is a combinational valid→ready path.
  - On acceptance, `rr_ptr <= i`. With no acceptance, `rr_ptr` holds.
- Pipeline, for acceptance at the end of cycle n:
  - Cycle n: ALU `a`/`b` are muxed from the granted requester. `s1 <= {valid, op, id}`.
  - Cycle n+1: ALU `op` is `s1_op`. `s2 <= {s1_valid, s1_id}`.
  - Cycle n+2: ALU `r` holds the result. If `s2_valid`, push `{s2_id, r}` into the FIFO.
  - Cycle n+3 at the earliest: `rsp_valid`=1.
- Idle driving:
  - With no grant, ALU `a`/`b` are 0.
  - With `s1_valid`=0, ALU `op` is 000.
  - The ALU's unreset registers are never observed, because `s2_valid` gates every push.
- FIFO: a pop occurs when `rsp_valid & rsp_ready`. Push and pop in the same cycle are legal at any occupancy, including full.
- Responses leave in issue order; there is no reordering.
- Requests must hold `a`/`b`/`op` stable while `req_valid`=1 and `req_ready`=0.
- Reset (async assert at any time):
  - Clears `s1_valid`, `s2_valid`, FIFO pointers and count.
  - Sets `rr_ptr = NUM_REQ-1`, so requester 0 wins first.
  - In-flight operations are dropped and produce no response.

## Timing
- Output values during reset: `req_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_r`=0, `busy`=0.
- Latency: 3 cycles from the accepting edge to `rsp_valid`, with an empty FIFO.
- Throughput: 1 operation per cycle sustained while `rsp_ready`=1. Worst-case occupancy is 3, below the depth of 4.
- Backpressure: with `rsp_ready`=0, at most FIFO_DEPTH operations are accepted; `req_ready` then stays 0 until a pop.
- `rsp_id` and `rsp_r` are registered FIFO outputs and stay stable while `rsp_valid & ~rsp_ready`.

## Structure
- Shared package `alu_pkg`:
  - `alu_op_e` (3-bit enum, names as above).
  - `DATA_W`=32.
  - `alu_rsp_t` struct `{id, r}`, parameterized by `ID_W` inside the module.
- Sub-module: the existing `alu`, instantiated once.
- The FIFO is internal logic, not a separate module.

## Test plan
- Single op, NUM_REQ=4: req0 sends a=7, b=−3, op=SUB → `rsp_valid` 3 cycles after acceptance, `rsp_id`=0, `rsp_r`=10.
- Round-robin: all four requesters valid and held, `rsp_ready`=1.
  - Grants go 0,1,2,3,0 on consecutive cycles.
  - Response ids arrive in the same order, one per cycle.
- Backpressure: `rsp_ready`=0 with req1 always valid.
  - Exactly 4 acceptances, then `req_ready`=0.
  - One pop re-enables exactly one acceptance.
  - Results are unchanged and in order.
- Opcode sweep: a=0x0000_00F0, b=0x0000_0FF0, all 8 ops → respectively:
  - ADD 0x10E0
  - SUB 0xFFFF_F100
  - NOT 0xFFFF_FF0F
  - NAND 0xFFFF_FF0F
  - NOR 0xFFFF_F00F
  - AND 0xF0
  - OR 0xFF0
  - XOR 0xF00
- Wrap: a=0x7FFF_FFFF, b=1, ADD → 0x8000_0000.
- Reset mid-flight:
  - Assert `rst_n`=0 one cycle after two acceptances → no response appears, `busy`=0.
  - After release, the first grant goes to requester 0.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcodes, data width and evaluation function
package alu_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    ADD  = 3'b000,
    SUB  = 3'b001,
    NOT  = 3'b010,
    NAND = 3'b011,
    NOR  = 3'b100,
    AND  = 3'b101,
    OR   = 3'b110,
    XOR  = 3'b111
  } alu_op_e;

  // Two's complement wrap-around; no overflow indication.
  function automatic logic [DATA_W-1:0] alu_eval(input alu_op_e op,
                                                 input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] res;
    res = '0;
    case (op)
      ADD:  res = a + b;
      SUB:  res = a - b;
      NOT:  res = ~a;
      NAND: res = ~(a & b);
      NOR:  res = ~(a | b);
      AND:  res = a & b;
      OR:   res = a | b;
      XOR:  res = a ^ b;
      default: res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - two-stage ALU: operands registered one edge, opcode applied the next
module alu
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  alu_op_e           op,
  output logic [DATA_W-1:0] r
);

  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;

  // Operand stage: capture a/b (no reset; consumers gate on their own valid).
  always_ff @(posedge clk) begin
    a_q <= a;
    b_q <= b;
  end

  // Result stage: opcode arrives one cycle after the operands.
  always_ff @(posedge clk) begin
    r <= alu_eval(op, a_q, b_q);
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one ALU with tagged, credit-protected response FIFO
module alu_arbiter
  import alu_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int FIFO_DEPTH = 4,
  localparam int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]  req_a,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]  req_b,
  input  logic [NUM_REQ-1:0][2:0]         req_op,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [ID_W-1:0]                 rsp_id,
  output logic [DATA_W-1:0]               rsp_r,
  output logic                            busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] r;
  } alu_rsp_t;

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_id;
  logic               grant_any;
  logic [ID_W-1:0]    cand;
  logic [ID_W-1:0]    rr_ptr;
  logic               can_issue;
  logic               issue;
  logic [CNT_W:0]     credit_used;

  logic               s1_valid;
  alu_op_e            s1_op;
  logic [ID_W-1:0]    s1_id;
  logic               s2_valid;
  logic [ID_W-1:0]    s2_id;

  logic [DATA_W-1:0]  alu_a;
  logic [DATA_W-1:0]  alu_b;
  alu_op_e            alu_op;
  logic [DATA_W-1:0]  alu_r;

  alu_rsp_t           mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               push;
  logic               pop;

  // Conservative credit: every in-flight op owns a FIFO slot; same-cycle pops are ignored.
  assign credit_used = (CNT_W+1)'(s1_valid) + (CNT_W+1)'(s2_valid) + (CNT_W+1)'(count);
  assign can_issue   = credit_used < (CNT_W+1)'(FIFO_DEPTH);

  // Round-robin search starting just after the last accepted requester.
  always_comb begin
    grant     = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!grant_any && req_valid[cand]) begin
        grant_any   = 1'b1;
        grant[cand] = 1'b1;
        grant_id    = cand;
      end
    end
  end

  // Ready is held low during reset even though the credit logic would allow issue.
  assign req_ready = grant & {NUM_REQ{can_issue & rst_n}};
  assign issue     = |req_ready;

  assign alu_a  = grant_any ? req_a[grant_id] : '0;
  assign alu_b  = grant_any ? req_b[grant_id] : '0;
  assign alu_op = s1_valid ? s1_op : ADD;

  alu u_alu (
    .clk (clk),
    .a   (alu_a),
    .b   (alu_b),
    .op  (alu_op),
    .r   (alu_r)
  );

  // Arbiter pointer and the valid/op/id shadow pipeline tracking the ALU stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr   <= ID_W'(NUM_REQ - 1);
      s1_valid <= 1'b0;
      s1_op    <= ADD;
      s1_id    <= '0;
      s2_valid <= 1'b0;
      s2_id    <= '0;
    end else begin
      if (issue) begin
        rr_ptr <= grant_id;
      end
      s1_valid <= issue;
      s1_op    <= alu_op_e'(req_op[grant_id]);
      s1_id    <= grant_id;
      s2_valid <= s1_valid;
      s2_id    <= s1_id;
    end
  end

  assign push = s2_valid;
  assign pop  = rsp_valid & rsp_ready;

  // Response FIFO; storage is cleared so the head reads zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{id: s2_id, r: alu_r};
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign rsp_valid = (count != '0);
  assign rsp_id    = mem[rd_ptr].id;
  assign rsp_r     = mem[rd_ptr].r;
  assign busy      = s1_valid | s2_valid | rsp_valid;

  // The credit check must make a push into a full FIFO (without a pop) impossible.
  no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (count == CNT_W'(FIFO_DEPTH))));

endmodule
